// File: rtl/or_combination_scheduler.sv
// Sequential r-of-SIZE combination scanner: walks every candidate mask once,
// one per clock, and reports whether any r-subset of nums is fully set.
//
// state | meaning
// IDLE  | waiting for start; last results held
// SCAN  | evaluating candidate v, v = 0 .. 2^SIZE-1
// DONE  | one-cycle done pulse, results final
module or_combination_scheduler #(
    parameter int SIZE = 5,
    parameter int RW   = 3,
    parameter int CW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] nums,
    input  logic [RW-1:0]   r,
    output logic            busy,
    output logic            done,
    output logic            result,
    output logic [SIZE-1:0] first_mask,
    output logic [CW-1:0]   match_count,
    output logic [CW-1:0]   comb_count
);

    localparam int PW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic            rst_sync_q;
    logic            accept;
    logic [SIZE-1:0] v;
    logic [SIZE-1:0] nums_q;
    logic [RW-1:0]   r_q;
    logic [PW-1:0]   pop;
    logic            is_comb;
    logic            is_match;

    // Start is gated until one clean edge has passed after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 1'b0;
        else        rst_sync_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start && rst_sync_q) begin
                    accept   = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN:    if (v == '1) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < SIZE; i++) pop = pop + PW'(v[i]);
    end

    assign is_comb  = (32'(pop) == 32'(r_q));
    assign is_match = is_comb && ((v & nums_q) == v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nums_q      <= '0;
            r_q         <= '0;
            v           <= '0;
            result      <= 1'b0;
            first_mask  <= '0;
            match_count <= '0;
            comb_count  <= '0;
        end else if (accept) begin
            nums_q      <= nums;
            r_q         <= r;
            v           <= '0;
            result      <= 1'b0;
            first_mask  <= '0;
            match_count <= '0;
            comb_count  <= '0;
        end else if (state == SCAN) begin
            if (is_comb && (comb_count != '1))
                comb_count <= comb_count + CW'(1);
            if (is_match) begin
                if (match_count != '1) match_count <= match_count + CW'(1);
                result <= 1'b1;
                // result is still clear only before the first match
                if (!result) first_mask <= v;
            end
            if (v != '1) v <= v + SIZE'(1);
        end
    end

    assign busy = (state == SCAN);
    assign done = (state == DONE);

endmodule

// File: doc/or_combination_scheduler.md
# or_combination_scheduler

Sequential controller that evaluates every r-element combination of a SIZE-bit submodule status vector and reports whether any combination is fully set, the lexicographically first such combination, and match/combination counts. It replaces single-shot combinational combination-OR evaluation in the capacitor-voltage sorting path. Scanning one candidate mask per clock keeps logic depth independent of SIZE. Handshake is start/busy/done toward the sorting sequencer.

## Interface
- SIZE, 5: width of status vector nums; supported 2..12
- RW, 3: width of r; 2^RW-1 may exceed SIZE
- CW, 8: width of count outputs; must hold C(SIZE, floor(SIZE/2))
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request evaluation; sampled only in IDLE
- nums  input  SIZE  status vector; latched on accepted start
- r  input  RW  combination size; latched on accepted start
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse; results valid
- result  output  1  at least one matching combination
- first_mask  output  SIZE  numerically smallest matching mask, 0 if none
- match_count  output  CW  number of matching combinations, saturating
- comb_count  output  CW  number of r-combinations evaluated, saturating

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: start=1 latches nums_q and r_q, clears result/first_mask/match_count/comb_count, sets candidate v=0, goes to SCAN.
- SCAN: one candidate v per cycle, v = 0 .. 2^SIZE-1 ascending.
  - v is a combination iff popcount(v) == r_q; comb_count increments.
  - Combination matches iff (v & nums_q) == v; match_count increments; result set.
  - first_mask loads v on the first match only.
  - After v = 2^SIZE-1, go to DONE; v does not wrap within a scan.
- DONE: done=1 for one cycle, then IDLE.
- Counters saturate at 2^CW-1.
- result/first_mask/match_count/comb_count hold from done until the next accepted start.
- r_q = 0: only v=0 qualifies; empty AND is true -> result=1, first_mask=0, counts 1.
- r_q > SIZE: no candidate qualifies -> result=0, counts 0, first_mask=0.
- start while busy or in DONE: ignored, no queuing.
- nums/r changes after acceptance: no effect on the running scan.
- Popcount on v is combinational, SIZE-bit adder tree.

## Timing
- Reset (rst_n=0, async): state IDLE. busy, done, result, first_mask, match_count, comb_count = 0. Internal v and latches = 0.
- Reset deassertion is synchronised internally; first start accepted on the second edge after rst_n rises.
- Cycle 0: start sampled high in IDLE.
- Cycles 1..2^SIZE: busy=1, candidate v = cycle-1 evaluated.
- Cycle 2^SIZE+1: busy=0, done=1, outputs final.
- Start-to-done latency: 2^SIZE+1 cycles, independent of nums and r. For SIZE=5 this is 33 cycles.
- Earliest next start is accepted on cycle 2^SIZE+2 (back in IDLE).
- rst_n low mid-scan: immediate abort to reset values. No done pulse.

## Test plan
- Reset/idle: hold rst_n=0, then release; no start -> all outputs 0 indefinitely. Pulse start with nums=11111, r=5 -> done exactly 33 cycles later; result=1, first_mask=11111, match_count=1, comb_count=1.
- Partial match: nums=10110, r=2 -> result=1, first_mask=00110, match_count=3, comb_count=10. Second run with nums=11111, r=3 -> match_count=10, first_mask=00111, comb_count=10.
- Boundaries:
  - r=0, nums=00000 -> result=1, first_mask=0, match_count=1, comb_count=1.
  - r=6 (>SIZE) -> result=0, both counts 0.
  - nums=00001, r=2 -> result=0, first_mask=0, match_count=0, comb_count=10.
- Start abuse: start held high through a scan, and nums/r changed mid-scan -> single done pulse at cycle 33 with results from the latched inputs. Next scan is accepted at cycle 34.
- Reset mid-operation: assert rst_n=0 at cycle 10 of a scan -> busy and all outputs 0 asynchronously, no done. A fresh start afterwards completes with correct values.
- Random check: random nums and r over 200 runs; compare against reference model: result = (popcount(nums) >= r); match_count = C(popcount(nums), r); comb_count = C(SIZE, r).
